imem_stream_loader: RTL and testbench
=====================================

Name: imem_stream_loader

Overview:
Program loader that writes the instruction memory, which the MIPS core reads. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written to consecutive instruction-memory addresses starting at 0. The core is held in reset until a complete frame with a correct checksum has been loaded. This replaces the bench-only hierarchical preload with a synthesizable path.

Parameters:
DEPTH, 256, instruction-memory depth in words
ADDR_W, 8, width of mem_addr (clog2(DEPTH))
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock
rst  in  1  reset (see Behaviour)
in_valid  in  1  byte available
in_data  in  8  stream byte
in_ready  out  1  loader can accept a byte
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  instruction word
cpu_rst  out  1  hold core in reset
done  out  1  frame loaded successfully (sticky)
err  out  1  frame error (sticky until next sync accepted)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_rst=1, done=0, err=0
  - state=SYNC
- A byte is accepted on the rising edge where in_valid && in_ready are both 1.
- Frame format: SYNC_BYTE, CNT_HI, CNT_LO, N×4 payload bytes (MSB first), CHK.
  - N = {CNT_HI,CNT_LO} words.
  - CHK = XOR of all payload bytes.
- FSM states: SYNC, CNT_HI, CNT_LO, PAYLOAD, CHECK, DONE.
  - SYNC: non-sync bytes are discarded. On SYNC_BYTE: clear err, clear the checksum accumulator, set word address=0, go to CNT_HI.
  - CNT_HI -> CNT_LO: latch the high count byte.
  - CNT_LO, N==0: go to CHECK.
  - CNT_LO, N>DEPTH: set err=1, go to SYNC. No writes occur.
  - CNT_LO, otherwise: go to PAYLOAD.
  - PAYLOAD: shift bytes into a 32-bit assembly register and XOR each into the checksum. A 2-bit byte counter tracks position.
    - On the 4th byte: the next cycle has mem_we=1 for exactly one cycle, with mem_addr=word index and mem_wdata=assembled word.
    - Word index then increments. After word N-1 is accepted, go to CHECK.
  - CHECK, CHK matches: done=1, cpu_rst=0, go to DONE.
  - CHECK, CHK mismatches: err=1, cpu_rst stays 1, go to SYNC. Words already written are not rolled back.
  - DONE: in_ready=0, and the state is held until rst.
- in_ready=1 in every state except DONE. The loader never back-pressures mid-frame.
- The write strobe is registered, so consecutive words are spaced at least 4 cycles apart. There is no conflict between a write and the next accept.
- mem_addr holds its last value when mem_we=0.
- A rst pulse mid-frame aborts the frame. All outputs return to reset values, and partial words are not written.
- in_valid gaps of any length within a frame are legal. There is no timeout.

Decomposition:
- Shared package mips_loader_pkg holds:
  - the state enum/localparams (SYNC..DONE)
  - SYNC_BYTE
  - the frame field widths (count 16 bits, word 32 bits)
- Sub-module word_assembler:
  - 8-to-32 shift register plus 2-bit byte counter and running XOR
  - outputs word_valid for one cycle and the current checksum
  - cleared by the FSM on sync.
- The FSM, address counter and strobes stay in the top level.

Test Plan:
- Nominal load:
  - Stimulus: stream A5 00 02 02 30 90 20 02 30 90 22 02.
  - Writes: addr0=32'h02309020, then addr1=32'h02309022.
  - Completion: done=1, cpu_rst=0 the cycle after CHK is accepted, err=0, in_ready=0 afterwards.
- Bad checksum:
  - Stimulus: same frame with CHK=03.
  - Response: both words written, err=1, done=0, cpu_rst=1, FSM back in SYNC (in_ready=1).
  - Recovery: a following correct frame clears err on its A5 and completes.
- Oversize count:
  - Stimulus: A5 01 01 (N=257 > 256).
  - Response: err=1 right after CNT_LO, no mem_we ever asserted. Subsequent payload-like bytes are discarded until A5.
- Garbage and empty frame:
  - Stimulus: 00 FF 13 A5 00 00 00.
  - Response: leading bytes ignored, no writes, done=1, cpu_rst=0.
- Throttled input with mid-frame reset:
  - Stimulus: in_valid toggled randomly during payload → same writes as the nominal load.
  - Reset case: rst asserted after 6 payload bytes of a 2-word frame.
  - Response: exactly one write (addr0), then all outputs at reset values; a fresh frame loads correctly from addr0.
- Full depth:
  - Stimulus: N=256, word k = 32'h0000_0000+k.
  - Response: last write addr=255 data=32'h000000FF, mem_addr does not wrap, done=1 with correct CHK.

Source files
------------

// File: rtl/imem_stream_loader_pkg.sv
// Shared definitions for the instruction-memory stream loader.
//   state_e   : loader FSM states (SYNC, CNT_HI, CNT_LO, PAYLOAD, CHECK, DONE)
//   SYNC_BYTE : default frame start marker
//   CNT_W     : width of the word-count field in the frame header
//   WORD_W    : width of an assembled instruction word
package mips_loader_pkg;

  typedef enum logic [2:0] {
    StSync,
    StCntHi,
    StCntLo,
    StPayload,
    StCheck,
    StDone
  } state_e;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned WORD_W    = 32;

endpackage

// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and instruction-memory / core-control outputs of the loader.
//   in_valid/in_data/in_ready : byte stream, accepted when in_valid && in_ready
//   mem_we/mem_addr/mem_wdata : instruction-memory write port
//   cpu_rst/done/err          : core reset hold and load status
// master drives the stream; slave is the loader.
interface imem_stream_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err
  );
endinterface

// File: rtl/imem_stream_loader_word.sv
// Byte-to-word assembler for the loader payload.
//   clk_i, rst_i   : clock and synchronous active-high reset
//   clear_i        : restart assembly and checksum (frame sync)
//   shift_en_i     : accepted payload byte present on data_i
//   word_valid_o   : high in the cycle the 4th byte of a word is accepted
//   word_o         : assembled big-endian word, valid with word_valid_o
//   chk_o          : XOR of all payload bytes accepted since clear_i
module word_assembler
  import mips_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              shift_en_i,
  input  logic [7:0]        data_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o,
  output logic [7:0]        chk_o
);

  // Only the first three bytes need storage; the 4th comes straight from data_i.
  logic [WORD_W-9:0] shreg_q;
  logic [1:0]        cnt_q;
  logic [7:0]        chk_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      chk_q   <= '0;
    end else if (shift_en_i) begin
      shreg_q <= {shreg_q[WORD_W-17:0], data_i};
      cnt_q   <= cnt_q + 2'd1;
      chk_q   <= chk_q ^ data_i;
    end
  end

  always_comb begin
    word_o       = {shreg_q, data_i};
    word_valid_o = shift_en_i && (cnt_q == 2'd3);
    chk_o        = chk_q;
  end

endmodule

// File: rtl/imem_stream_loader.sv
// Framed program loader for the MIPS instruction memory.
// Frame: SYNC_BYTE, CNT_HI, CNT_LO, N x 4 payload bytes (MSB first), CHK (XOR of payload).
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of imem_stream_loader_if (stream in, memory write out, status)
// The core is held in cpu_rst until a frame with a matching checksum has been written.
module imem_stream_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = mips_loader_pkg::SYNC_BYTE
) (
  input logic                 clk,
  input logic                 rst,
  imem_stream_loader_if.slave bus
);
  import mips_loader_pkg::*;

  state_e              state_q, state_d;
  logic [7:0]          cnt_hi_q, cnt_hi_d;
  logic [ADDR_W-1:0]   last_q, last_d;     // index of the final word (N-1)
  logic [ADDR_W-1:0]   widx_q, widx_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic                clear;
  logic                shift_en;
  logic                word_valid;
  logic [WORD_W-1:0]   word;
  logic [7:0]          chk;
  logic [CNT_W-1:0]    n;

  assign bus.in_ready  = (state_q != StDone);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign shift_en = accept && (state_q == StPayload);
  assign n        = {cnt_hi_q, bus.in_data};

  word_assembler u_word (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .shift_en_i   (shift_en),
    .data_i       (bus.in_data),
    .word_valid_o (word_valid),
    .word_o       (word),
    .chk_o        (chk)
  );

  always_comb begin
    state_d     = state_q;
    cnt_hi_d    = cnt_hi_q;
    last_d      = last_q;
    widx_d      = widx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    err_d       = err_q;
    clear       = 1'b0;

    case (state_q)
      StSync: begin
        if (accept && (bus.in_data == SYNC_BYTE)) begin
          err_d   = 1'b0;
          clear   = 1'b1;
          widx_d  = '0;
          state_d = StCntHi;
        end
      end
      StCntHi: begin
        if (accept) begin
          cnt_hi_d = bus.in_data;
          state_d  = StCntLo;
        end
      end
      StCntLo: begin
        if (accept) begin
          if (n == '0) begin
            state_d = StCheck;
          end else if (32'(n) > DEPTH) begin
            err_d   = 1'b1;
            state_d = StSync;
          end else begin
            last_d  = ADDR_W'(n - CNT_W'(1));
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (word_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = widx_q;
          mem_wdata_d = word;
          // Compare before incrementing so a full-depth frame never wraps the index.
          if (widx_q == last_q) state_d = StCheck;
          else                  widx_d  = widx_q + ADDR_W'(1);
        end
      end
      StCheck: begin
        if (accept) begin
          if (bus.in_data == chk) begin
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
            state_d   = StDone;
          end else begin
            err_d   = 1'b1;
            state_d = StSync;
          end
        end
      end
      StDone:  ;
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StSync;
      cnt_hi_q    <= '0;
      last_q      <= '0;
      widx_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_hi_q    <= cnt_hi_d;
      last_q      <= last_d;
      widx_q      <= widx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed and randomized bench for imem_stream_loader. Frames are built from word lists;
// the expected memory image and status follow from the frame contents alone.
module tb_imem_stream_loader;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  imem_stream_loader_if #(.ADDR_W(8)) bus ();

  imem_stream_loader #(
    .DEPTH     (256),
    .ADDR_W    (8),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  tx[$];     // bytes to send
  logic [31:0] exp_w[$];  // expected words, written from address 0 upward
  logic [39:0] wq[$];     // observed writes {addr, data}

  logic [7:0] nom [11] = '{8'hA5, 8'h00, 8'h02, 8'h02, 8'h30, 8'h90, 8'h20,
                           8'h02, 8'h30, 8'h90, 8'h22};
  logic [7:0] garb [7] = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00};

  always @(negedge clk) if (bus.mem_we) wq.push_back({bus.mem_addr, bus.mem_wdata});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_cpu_rst"}, 64'(bus.cpu_rst), 64'd1);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_err"}, 64'(bus.err), 64'd0);
  endtask

  task automatic check_writes(input string tag);
    int m;
    check({tag, "_wcount"}, 64'(wq.size()), 64'(exp_w.size()));
    m = (wq.size() < exp_w.size()) ? wq.size() : exp_w.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(wq[i][39:32]), 64'(i));
      check($sformatf("%s_data%0d", tag, i), 64'(wq[i][31:0]), 64'(exp_w[i]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input bit thr);
    if (thr) repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic send_range(input int from, input int upto, input bit thr);
    for (int i = from; i < upto; i++) send_byte(tx[i], thr);
  endtask

  // kind 0: random words, kind 1: word k = k. badchk flips the checksum.
  task automatic make_frame(input int n, input bit kind, input bit badchk);
    logic [7:0]  x;
    logic [31:0] w;
    logic [15:0] nn;
    tx.delete();
    exp_w.delete();
    nn = 16'(n);
    x  = 8'h00;
    tx.push_back(8'hA5);
    tx.push_back(nn[15:8]);
    tx.push_back(nn[7:0]);
    for (int k = 0; k < n; k++) begin
      w = kind ? 32'(k) : $urandom;
      exp_w.push_back(w);
      for (int j = 0; j < 4; j++) begin
        tx.push_back(w[31-8*j -: 8]);
        x = x ^ w[31-8*j -: 8];
      end
    end
    tx.push_back(badchk ? (x ^ 8'h01) : x);
  endtask

  task automatic load_nominal(input logic [7:0] chkb);
    tx.delete();
    exp_w.delete();
    for (int i = 0; i < 11; i++) tx.push_back(nom[i]);
    tx.push_back(chkb);
    exp_w.push_back(32'h02309020);
    exp_w.push_back(32'h02309022);
  endtask

  initial begin
    logic [7:0] junk;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("rst0");

    // Nominal load
    load_nominal(8'h02);
    send_range(0, tx.size(), 1'b0);
    check("nom_done", 64'(bus.done), 64'd1);
    check("nom_cpu_rst", 64'(bus.cpu_rst), 64'd0);
    check("nom_err", 64'(bus.err), 64'd0);
    check("nom_in_ready", 64'(bus.in_ready), 64'd0);
    check_writes("nom");
    do_reset();
    check_reset("rst1");

    // Bad checksum, then recovery
    load_nominal(8'h03);
    send_range(0, tx.size(), 1'b0);
    check_writes("badchk");
    check("badchk_err", 64'(bus.err), 64'd1);
    check("badchk_done", 64'(bus.done), 64'd0);
    check("badchk_cpu_rst", 64'(bus.cpu_rst), 64'd1);
    check("badchk_in_ready", 64'(bus.in_ready), 64'd1);
    make_frame(3, 1'b0, 1'b0);
    wq.delete();
    send_byte(tx[0], 1'b0);
    check("recov_err_clr", 64'(bus.err), 64'd0);
    send_range(1, tx.size(), 1'b1);
    check_writes("recov");
    check("recov_done", 64'(bus.done), 64'd1);
    do_reset();

    // Oversize count
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("ovf_err", 64'(bus.err), 64'd1);
    for (int i = 0; i < 8; i++) begin
      junk = 8'($urandom);
      if (junk == 8'hA5) junk = 8'h00;
      send_byte(junk, 1'b0);
    end
    check("ovf_nowrite", 64'(wq.size()), 64'd0);
    check("ovf_err_hold", 64'(bus.err), 64'd1);
    check("ovf_in_ready", 64'(bus.in_ready), 64'd1);
    check("ovf_done", 64'(bus.done), 64'd0);
    do_reset();

    // Garbage then empty frame
    for (int i = 0; i < 7; i++) send_byte(garb[i], 1'b0);
    check("empty_nowrite", 64'(wq.size()), 64'd0);
    check("empty_done", 64'(bus.done), 64'd1);
    check("empty_cpu_rst", 64'(bus.cpu_rst), 64'd0);
    do_reset();

    // Throttled random frame
    make_frame(4, 1'b0, 1'b0);
    send_range(0, tx.size(), 1'b1);
    check_writes("thr");
    check("thr_done", 64'(bus.done), 64'd1);
    do_reset();

    // Reset after 6 payload bytes of a 2-word frame
    make_frame(2, 1'b0, 1'b0);
    send_range(0, 9, 1'b1);
    check("mid_wcount", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) begin
      check("mid_addr0", 64'(wq[0][39:32]), 64'd0);
      check("mid_data0", 64'(wq[0][31:0]), 64'(exp_w[0]));
    end
    do_reset();
    check_reset("rst_mid");
    make_frame(2, 1'b0, 1'b0);
    send_range(0, tx.size(), 1'b1);
    check_writes("mid_fresh");
    check("mid_fresh_done", 64'(bus.done), 64'd1);
    do_reset();

    // Full depth
    make_frame(256, 1'b1, 1'b0);
    send_range(0, tx.size(), 1'b0);
    check_writes("full");
    check("full_mem_addr", 64'(bus.mem_addr), 64'd255);
    check("full_mem_wdata", 64'(bus.mem_wdata), 64'h0000_00FF);
    check("full_done", 64'(bus.done), 64'd1);
    check("full_err", 64'(bus.err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
